// File: rtl/sha3_pkg.sv
// Shared SHA-3 definitions: mode encoding, digest sizes and FSM states for the
// output serializer.
package sha3_pkg;

  localparam int MAX_DIGEST = 512;
  localparam int STATE_W    = 1600;

  typedef enum logic [1:0] {
    SHA3_512 = 2'b00,
    SHA3_384 = 2'b01,
    SHA3_256 = 2'b11,
    SHA3_224 = 2'b10
  } sha3_mode_e;

  typedef enum logic {
    SER_IDLE,
    SER_SEND
  } ser_state_e;

  function automatic int unsigned digest_bits(sha3_mode_e m);
    case (m)
      SHA3_512: digest_bits = 512;
      SHA3_384: digest_bits = 384;
      SHA3_256: digest_bits = 256;
      default:  digest_bits = 224;
    endcase
  endfunction

endpackage

// File: rtl/output_pattern_serializer.sv
// Captures the digest bits of the permuted Keccak state and streams them out
// MSB-first as WORD_W-bit words over a valid/ready port.
module output_pattern_serializer
  import sha3_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] state_in,
  input  logic [1:0]         mode,
  input  logic               start,
  output logic               busy,
  output logic [WORD_W-1:0]  dout_data,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               dout_last,
  output logic               done
);

  localparam int B         = WORD_W / 8;
  localparam int MAX_WORDS = MAX_DIGEST / WORD_W;
  localparam int CNT_W     = $clog2(MAX_WORDS);
  localparam int LOG_W     = $clog2(WORD_W);

  ser_state_e            state_q;
  logic [MAX_DIGEST-1:0] digest_q;
  logic [MAX_DIGEST-1:0] capture_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      last_idx_q;
  logic [CNT_W-1:0]      last_idx_d;
  logic                  busy_q, valid_q, last_q, done_q;
  int unsigned           dbits;
  logic [8:0]            sel_lsb;
  logic [WORD_W-1:0]     slice;
  logic                  unused_state_hi;

  assign unused_state_hi = ^state_in[STATE_W-1:MAX_DIGEST];

  assign dbits      = digest_bits(sha3_mode_e'(mode));
  assign last_idx_d = CNT_W'(dbits / WORD_W - 1);

  always_comb begin
    capture_d = '0;
    for (int unsigned i = 0; i < MAX_DIGEST; i++) begin
      if (i < dbits) capture_d[i] = state_in[i];
    end
  end

  // Word k occupies digest bits [k*W +: W]; its lowest byte must land in the MSBs.
  assign sel_lsb = {cnt_q, {LOG_W{1'b0}}};
  assign slice   = digest_q[sel_lsb +: WORD_W];

  always_comb begin
    dout_data = '0;
    for (int unsigned i = 0; i < B; i++) begin
      dout_data[WORD_W-1-8*i -: 8] = slice[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SER_IDLE;
      digest_q   <= '0;
      cnt_q      <= '0;
      last_idx_q <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SER_IDLE: begin
          if (start) begin
            digest_q   <= capture_d;
            last_idx_q <= last_idx_d;
            cnt_q      <= '0;
            state_q    <= SER_SEND;
            busy_q     <= 1'b1;
            valid_q    <= 1'b1;
            last_q     <= (last_idx_d == '0);
          end
        end
        SER_SEND: begin
          if (valid_q && dout_ready) begin
            if (last_q) begin
              state_q  <= SER_IDLE;
              digest_q <= '0;
              cnt_q    <= '0;
              busy_q   <= 1'b0;
              valid_q  <= 1'b0;
              last_q   <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              cnt_q  <= cnt_q + 1'b1;
              last_q <= (cnt_q + 1'b1 == last_idx_q);
            end
          end
        end
        default: state_q <= SER_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign dout_valid = valid_q;
  assign dout_last  = last_q;
  assign done       = done_q;

endmodule
